// File: rtl/mips_muldiv_pkg.sv
// Shared encodings, FSM states and op-decoding helpers for the HI/LO
// multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [1:0] op);
    return !((op == OP_MULT) || (op == OP_MULTU));
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator pair: shift-add for
// multiply (LSB first), restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_is_div,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The partial remainder stays below the divisor, so the shifted value
  // fits in WIDTH+1 bits and a successful subtract fits back in WIDTH.
  always_comb begin
    w_sum     = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : '0);
    w_shifted = {i_acc_hi, i_acc_lo[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_operand});
    w_diff    = w_shifted[WIDTH-1:0] - i_operand;
    if (i_is_div) begin
      o_next_hi = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      o_next_lo = {i_acc_lo[WIDTH-2:0], w_fits};
    end else begin
      o_next_hi = w_sum[WIDTH:1];
      o_next_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; works on magnitudes and
// applies sign correction in a final FIX cycle.
module hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_next_state;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_op;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_div_zero;
  logic             r_done;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_start_signed;
  logic             w_start_div;
  logic [WIDTH-1:0] w_mag_rs;
  logic [WIDTH-1:0] w_mag_rt;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod_fixed;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc_hi  (r_acc_hi),
    .i_acc_lo  (r_acc_lo),
    .i_operand (r_operand),
    .i_is_div  (is_div(r_op)),
    .o_next_hi (w_step_hi),
    .o_next_lo (w_step_lo)
  );

  always_comb begin
    w_start_signed = is_signed(op);
    w_start_div    = is_div(op);
    w_mag_rs       = (w_start_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    w_mag_rt       = (w_start_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  end

  // Remainder follows the dividend's sign; a zero divisor returns all-ones
  // quotient and the untouched dividend.
  always_comb begin
    w_prod_raw   = {r_acc_hi, r_acc_lo};
    w_prod_fixed = (r_neg_a ^ r_neg_b) ? -w_prod_raw : w_prod_raw;
    w_fix_hi     = w_prod_fixed[2*WIDTH-1:WIDTH];
    w_fix_lo     = w_prod_fixed[WIDTH-1:0];
    if (is_div(r_op)) begin
      if (r_div_zero) begin
        w_fix_hi = r_dividend;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_a ? -r_acc_hi : r_acc_hi;
        w_fix_lo = (r_neg_a ^ r_neg_b) ? -r_acc_lo : r_acc_lo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CALC;
      CALC:    if (r_count == '0) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_op       <= OP_MULT;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_dividend <= '0;
      r_operand  <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_op       <= op;
            r_neg_a    <= w_start_signed & rs_data[WIDTH-1];
            r_neg_b    <= w_start_signed & rt_data[WIDTH-1];
            r_div_zero <= (rt_data == '0);
            r_dividend <= rs_data;
            r_operand  <= w_start_div ? w_mag_rt : w_mag_rs;
            r_acc_hi   <= '0;
            r_acc_lo   <= w_start_div ? w_mag_rs : w_mag_rt;
            r_count    <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          r_count  <= r_count - CW'(1);
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != IDLE);
    done   = r_done;
    hi_out = (mthi && !busy) ? wdata : r_hi;
    lo_out = (mtlo && !busy) ? wdata : r_lo;
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table plus random ops through
// a result scoreboard, and hand sequences for reset, MT writes and busy.
module tb_hilo_muldiv;
  import mips_muldiv_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;
  localparam int NVEC    = 12;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vector_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          checks = 0;
  int          errors = 0;
  result_t     expQ[$];
  logic [31:0] lastHi;
  logic [31:0] lastLo;
  vector_t     vecs[NVEC];

  hilo_muldiv #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model built on 64-bit arithmetic, independent of the datapath.
  function automatic result_t model(input logic [1:0] mOp, input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sq;
    logic signed [63:0] sr;
    logic [63:0]        p;
    result_t            r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    r  = '0;
    case (mOp)
      OP_MULT: begin
        sq = sa * sb;
        r  = {sq[63:32], sq[31:0]};
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        r = {p[63:32], p[31:0]};
      end
      OP_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Drives start for one cycle from a negedge; returns at the negedge after E0.
  task automatic applyStimulus(input logic [1:0] aOp, input logic [31:0] aRs,
                               input logic [31:0] aRt, input logic [31:0] eHi,
                               input logic [31:0] eLo);
    result_t e;
    e       = {eHi, eLo};
    start   = 1'b1;
    op      = aOp;
    rs_data = aRs;
    rt_data = aRt;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checks latency/busy, pops and compares HI/LO.
  task automatic checkOutput(input string name, input int expEdges);
    int      edges;
    bit      seen;
    bit      busyOk;
    result_t e;
    edges  = 0;
    seen   = 0;
    busyOk = 1;
    compareVal({name, "_busy_start"}, {31'b0, busy}, 32'd1);
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) seen = 1;
      else if (!busy) busyOk = 0;
    end
    compareVal({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    compareVal({name, "_latency"}, edges, expEdges);
    compareVal({name, "_busy_held"}, {31'b0, busyOk}, 32'd1);
    compareVal({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got result, wanted empty queue entry", name);
    end else begin
      e = expQ.pop_front();
      compareVal({name, "_hi"}, hi_out, e.hi);
      compareVal({name, "_lo"}, lo_out, e.lo);
      lastHi = e.hi;
      lastLo = e.lo;
    end
  endtask

  initial begin
    int      pulses;
    result_t m;
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{OP_MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

    rst_n = 1'b0; start = 1'b0; op = OP_MULT; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    lastHi = '0; lastLo = '0;
    repeat (3) @(negedge clk);
    compareVal("reset_busy", {31'b0, busy}, 32'd0);
    compareVal("reset_done", {31'b0, done}, 32'd0);
    compareVal("reset_hi", hi_out, 32'd0);
    compareVal("reset_lo", lo_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload both registers, then abort an operation with reset.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    compareVal("dual_mt_hi", hi_out, 32'hDEADBEEF);
    compareVal("dual_mt_lo", lo_out, 32'hDEADBEEF);
    applyStimulus(OP_MULTU, 32'd5, 32'd7, 32'd0, 32'd35);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compareVal("abort_busy", {31'b0, busy}, 32'd0);
    compareVal("abort_done", {31'b0, done}, 32'd0);
    compareVal("abort_hi", hi_out, 32'd0);
    compareVal("abort_lo", lo_out, 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    compareVal("abort_no_done", pulses, 32'd0);
    compareVal("abort_idle", {31'b0, busy}, 32'd0);

    // Table vectors; each start lands in the previous done cycle.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].expHi, vecs[i].expLo);
      checkOutput($sformatf("vec%0d", i), LATENCY);
    end

    @(negedge clk);
    mthi = 1'b1; wdata = 32'hA5A5A5A5;
    #1 compareVal("mthi_bypass", hi_out, 32'hA5A5A5A5);
    @(negedge clk);
    mthi = 1'b0; wdata = '0;
    #1;
    compareVal("mthi_held", hi_out, 32'hA5A5A5A5);
    compareVal("mthi_lo_kept", lo_out, lastLo);
    lastHi = 32'hA5A5A5A5;

    // MT writes, start and operand changes while busy must all be ignored.
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (5) @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00000055; start = 1'b1;
    op = OP_MULT; rs_data = 32'h11111111; rt_data = 32'd3;
    #1;
    compareVal("busy_lo_no_bypass", lo_out, lastLo);
    compareVal("busy_hi_no_bypass", hi_out, lastHi);
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0; wdata = '0;
    rs_data = 32'hFFFF0000; rt_data = 32'd0;
    checkOutput("busy_ignore", LATENCY - 6);
    @(negedge clk);
    compareVal("no_queued_start", {31'b0, busy}, 32'd0);
    compareVal("busy_ignore_lo_kept", lo_out, 32'd14);
    compareVal("busy_ignore_hi_kept", hi_out, 32'd2);

    // MTHI together with start: written at E0, then overwritten by the result.
    mthi = 1'b1; wdata = 32'h0BADF00D;
    applyStimulus(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    mthi = 1'b0; wdata = '0;
    #1;
    compareVal("start_mthi_hi", hi_out, 32'h0BADF00D);
    compareVal("start_mthi_lo", lo_out, 32'd14);
    checkOutput("start_mthi", LATENCY);

    for (int i = 0; i < 8; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = $urandom[0] ? 32'($urandom_range(1, 20)) : $urandom;
      m   = model(rOp, rA, rB);
      applyStimulus(rOp, rA, rB, m.hi, m.lo);
      checkOutput($sformatf("rand%0d", i), LATENCY);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the HI and LO registers.
- Sits in the execute stage, downstream of the register-file read ports: its operands are the rs/rt read data.
- Also sits upstream of the register-file write port: `hi_out`/`lo_out` feed writeback for MFHI/MFLO.
- Iterative radix-2, one bit per cycle. The pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation in `op` using `rs_data`/`rt_data`; honoured only when idle
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_data  in  WIDTH  multiplicand / dividend
- rt_data  in  WIDTH  multiplier / divisor
- mthi  in  1  write `wdata` to HI
- mtlo  in  1  write `wdata` to LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse: HI/LO hold the new result
- hi_out  out  WIDTH  HI value, with MTHI bypass
- lo_out  out  WIDTH  LO value, with MTLO bypass

Behaviour:
- Reset (async assert, sync to clk on deassert in effect): state=IDLE, HI=LO=0, count=0, done=0, busy=0. Reset mid-operation aborts it; no partial result survives.
- States:
  - IDLE: start=1 -> latch operand magnitudes, sign flags, op, count=WIDTH-1; go to CALC. Else stay.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; count decrements. At count==0 the step is performed and the state goes to FIX.
  - FIX: apply sign correction, write HI/LO, set done=1, go to IDLE.
- Latency: start sampled at edge E0; CALC steps on E1..E(WIDTH); HI/LO written and done set on E(WIDTH+1). For WIDTH=32 that is 33 edges.
  - done high for exactly one cycle after E33.
  - busy high from after E0 through the cycle in which done is high? No: busy = (state != IDLE), so it is low in the done cycle.
- Multiply: 2*WIDTH-bit product; HI=upper half, LO=lower half.
  - MULT: signed operands; magnitudes multiplied, product negated if the signs differ.
  - MULTU: unsigned.
- Divide: LO=quotient, HI=remainder.
  - DIV: truncates toward zero; remainder takes the dividend's sign.
  - DIVU: unsigned.
  - Divide by zero (DIV or DIVU): LO=all ones, HI=rs_data unchanged. Still takes the full latency.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0, with no trap. This falls out of the magnitude/negation path and must be verified.
- Operands are captured at E0; changes to rs_data/rt_data during CALC have no effect.
- start while busy: ignored, no queueing.
- mthi/mtlo:
  - Honoured only when busy=0; ignored while busy.
  - In IDLE the register is written at the edge.
  - mthi and mtlo may both be asserted in one cycle; both are written with `wdata`.
  - start together with mthi/mtlo in IDLE: the MT write happens at E0 and the operation's result overwrites HI/LO at E(WIDTH+1).
- Bypass (combinational), mirroring the register-file write bypass:
  - hi_out = wdata when mthi && !busy, else HI.
  - lo_out likewise with mtlo.
- hi_out/lo_out are stable (old values) during CALC/FIX and change only on the done edge.

Decomposition:
- Shared package mips_muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state enum (IDLE, CALC, FIX)
  - helper is_div(op) = op[1], is_signed(op) = !op[0]
- One sub-module, muldiv_step: a purely combinational single iteration.
  - Inputs: {acc_hi, acc_lo}, operand magnitude, is_div.
  - Outputs: the next accumulator pair, so the top level holds only the FSM, counter, sign logic and HI/LO.

Test Plan:
- Reset mid-op: start MULTU 5*7, assert rst_n=0 at cycle 10 -> busy=0, done=0, hi_out=lo_out=0 immediately; no done pulse afterwards.
- MULT 0xFFFFFFFD(-3) * 7, start at E0 -> busy=1 on E0..E32; done=1 only after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU 0x1234/0 and DIV 0xFFFFFFF0/0 -> LO=0xFFFFFFFF, HI=dividend, latency 33.
- mthi=1, wdata=0xA5A5A5A5 while idle -> hi_out=0xA5A5A5A5 the same cycle (bypass) and stays after the edge. mtlo and start during busy -> ignored; LO and the in-flight result are unaffected.
- Back-to-back: start asserted in the done cycle -> accepted (state IDLE). Operand changes mid-CALC -> result uses the E0 operands.
